// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch queue between PC generation and decode.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package fetch_pkg;

  localparam int XLEN = 32;

  // Encoding of addi x0, x0, 0; decode sees this whenever nothing is valid.
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  // One queue slot: the requesting PC pair, the returned word, and whether
  // the word has come back yet.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] instr;
    logic            filled;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Fetch queue: issues PCs to imem, pairs in-order responses with their PCs, feeds decode.
// Latency: request accepted in cycle N, response in N+k, id_valid in N+k+1 (registered output).
// Backpressure: id_ready low fills the queue; requests stop when queued + dropped responses reach DEPTH.
//
// Ports:
//   clk, rst                     core clock, synchronous active-high reset
//   pc_in, pc_plus_four_in       current PC pair from the fetch stage
//   flush                        redirect; squashes everything and counts responses to discard
//   pc_advance                   PC register enable (request handshake or flush)
//   imem_req_*                   request channel (valid/ready), address = pc_in
//   imem_rsp_*                   in-order response strobe, no backpressure
//   id_*                         decode channel (valid/ready) carrying {instr, pc, pc+4}
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int              DEPTH     = 4,
  parameter logic [XLEN-1:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] pc_plus_four_in,
  input  logic            flush,
  output logic            pc_advance,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus_four
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;   // extra wrap bit separates full from empty

  fq_entry_t entries [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] fill;
  logic [PW-1:0] tail;
  logic [PW-1:0] drop_cnt;
  logic [PW-1:0] occ;
  logic [PW-1:0] inflight;
  logic [PW:0]   used;
  logic [PW:0]   flush_drop;

  logic [IW-1:0] head_idx;
  logic [IW-1:0] fill_idx;
  logic [IW-1:0] tail_idx;

  logic req_fire;
  logic rsp_drop;
  logic rsp_fill;
  logic deq;

  assign head_idx = head[IW-1:0];
  assign fill_idx = fill[IW-1:0];
  assign tail_idx = tail[IW-1:0];

  assign occ      = tail - head;
  assign inflight = tail - fill;

  // Squashed responses still in flight reserve slots too, so the total number
  // of outstanding requests never exceeds DEPTH.
  assign used = {1'b0, occ} + {1'b0, drop_cnt};

  assign imem_req_valid = !rst && !flush && (used < (PW+1)'(DEPTH));
  assign imem_req_addr  = pc_in;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign pc_advance     = !rst && (req_fire || flush);

  assign rsp_drop = imem_rsp_valid && (drop_cnt != '0);
  assign rsp_fill = imem_rsp_valid && (drop_cnt == '0) && (inflight != '0);

  // Everything not yet returned becomes a response to discard; a response
  // landing in the flush cycle itself is consumed right away.
  always_comb begin
    flush_drop = {1'b0, drop_cnt} + {1'b0, inflight};
    if (imem_rsp_valid && (flush_drop != '0)) begin
      flush_drop = flush_drop - (PW+1)'(1);
    end
  end

  assign id_valid        = !rst && entries[head_idx].filled && (occ != '0);
  assign deq             = id_valid && id_ready;
  assign id_instr        = id_valid ? entries[head_idx].instr : NOP_INSTR;
  assign id_pc           = entries[head_idx].pc;
  assign id_pc_plus_four = entries[head_idx].pc4;

  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= '0;
      fill     <= '0;
      tail     <= '0;
      drop_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else if (flush) begin
      head     <= '0;
      fill     <= '0;
      tail     <= '0;
      drop_cnt <= flush_drop[PW-1:0];
      for (int i = 0; i < DEPTH; i++) begin
        entries[i].filled <= 1'b0;
      end
    end else begin
      // The occupancy bound keeps tail, fill and head on distinct slots
      // whenever they are written in the same cycle.
      if (req_fire) begin
        entries[tail_idx].pc     <= pc_in;
        entries[tail_idx].pc4    <= pc_plus_four_in;
        entries[tail_idx].filled <= 1'b0;
        tail                     <= tail + PW'(1);
      end
      if (rsp_fill) begin
        entries[fill_idx].instr  <= imem_rsp_data;
        entries[fill_idx].filled <= 1'b1;
        fill                     <= fill + PW'(1);
      end
      if (rsp_drop) begin
        drop_cnt <= drop_cnt - PW'(1);
      end
      if (deq) begin
        head <= head + PW'(1);
      end
    end
  end

  // A response with nothing outstanding means imem broke its protocol.
  always @(posedge clk) begin
    if (!rst && imem_rsp_valid) begin
      assert (drop_cnt != '0 || inflight != '0)
        else $error("fetch_queue: imem response with no outstanding request");
    end
  end

endmodule
